// File: rtl/countdown_timer_bcd.sv
// ----------------------------------------------------------------------------
// countdown_timer_bcd
//   BCD countdown timer in MM:SS.cc form (minutes 00-99, seconds 00-59,
//   centiseconds 00-99). While running it decrements one centisecond per
//   clk_100Hz rising edge. It flags a borrow into seconds and pulses done when
//   the count reaches zero. The digit layout matches the up-counting clock
//   chain, so the display mux can show either source without remapping.
//
// Parameters
//   RST_VAL   BCD count loaded on reset {MM,SS,cc}; must be a valid BCD time
//   MIN_MAX   highest BCD minutes value accepted by load
//
// Ports
//   clk_100Hz  in   100 Hz timer clock, rising edge
//   rst        in   synchronous active-high reset
//   load       in   load load_val (level, sampled every edge)
//   load_val   in   BCD preset {MM[23:16], SS[15:8], cc[7:0]}
//   start      in   begin / resume counting
//   stop       in   pause counting
//   cnt_bcd    out  current BCD count, registered
//   state      out  00 IDLE, 01 RUN, 10 PAUSE, 11 DONE, registered
//   borrow_1s  out  RUN with cc==00 and a nonzero count (combinational)
//   done       out  one-cycle pulse when the count reaches zero
//   load_err   out  one-cycle pulse when a load is rejected
// ----------------------------------------------------------------------------
module countdown_timer_bcd #(
    parameter logic [23:0] RST_VAL = 24'h000000,
    parameter logic [7:0]  MIN_MAX = 8'h99
) (
    input  logic        clk_100Hz,
    input  logic        rst,
    input  logic        load,
    input  logic [23:0] load_val,
    input  logic        start,
    input  logic        stop,
    output logic [23:0] cnt_bcd,
    output logic [1:0]  state,
    output logic        borrow_1s,
    output logic        done,
    output logic        load_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } state_t;

    state_t      state_q, state_nxt;
    logic [23:0] cnt_q, cnt_nxt;
    logic        done_q, done_nxt;
    logic        err_q, err_nxt;
    logic        dec_en;
    logic        load_ok;

    // One-centisecond BCD decrement. Each digit wraps to 9 on borrow, except
    // the seconds-tens digit, which wraps to 5. The caller guarantees a
    // nonzero count, so the minutes-tens digit never borrows out.
    function automatic logic [23:0] bcd_dec(input logic [23:0] v);
        logic [23:0] r;
        logic        b;
        r = v;
        b = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (b) begin
                if (v[i*4 +: 4] == 4'd0) begin
                    r[i*4 +: 4] = (i == 3) ? 4'd5 : 4'd9;
                    b = 1'b1;
                end else begin
                    r[i*4 +: 4] = v[i*4 +: 4] - 4'd1;
                    b = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Every nibble must be a decimal digit and seconds must be below 60.
    // Once the nibbles are known to be valid BCD, a raw compare orders them
    // the same way a decimal compare would.
    function automatic logic bcd_time_ok(input logic [23:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (v[i*4 +: 4] > 4'd9) ok = 1'b0;
        end
        if (v[15:12] > 4'd5) ok = 1'b0;
        if (v[23:16] > MIN_MAX) ok = 1'b0;
        return ok;
    endfunction

    assign load_ok = bcd_time_ok(load_val);

    // State register
    always_ff @(posedge clk_100Hz) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= RST_VAL;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
            done_q  <= done_nxt;
            err_q   <= err_nxt;
        end
    end

    // Next-state logic. Priority is load > stop > start. A load during RUN is
    // rejected, but that edge still counts down as a normal RUN edge.
    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        dec_en    = 1'b0;

        if (load) begin
            if (state_q == RUN) begin
                err_nxt = 1'b1;
                dec_en  = 1'b1;
            end else if (load_ok) begin
                cnt_nxt   = load_val;
                state_nxt = IDLE;
            end else begin
                err_nxt = 1'b1;
            end
        end else begin
            case (state_q)
                RUN: begin
                    if (stop) state_nxt = PAUSE;
                    else      dec_en    = 1'b1;
                end
                IDLE, PAUSE: begin
                    // When start and stop arrive together, stop wins.
                    if (start && !stop && cnt_q != 24'h0) state_nxt = RUN;
                end
                default: ;
            endcase
        end

        if (dec_en) begin
            if (cnt_q == 24'h0) begin
                // Defensive: a zero count in RUN just parks in DONE.
                state_nxt = DONE;
            end else begin
                cnt_nxt = bcd_dec(cnt_q);
                if (cnt_q == 24'h000001) begin
                    state_nxt = DONE;
                    done_nxt  = 1'b1;
                end
            end
        end
    end

    // Outputs
    always_comb begin
        cnt_bcd   = cnt_q;
        state     = state_q;
        done      = done_q;
        load_err  = err_q;
        borrow_1s = (state_q == RUN) && (cnt_q[7:0] == 8'h00) && (cnt_q != 24'h0);
    end

endmodule
